// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: walks the digits one slot at a time,
// blanks between digits and swaps in new display data only on frame boundaries.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    output logic [3:0]              bcd_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
    logic                    pending_q, pending_d;
    logic [3:0]              bcd_q, bcd_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
    logic                    frame_done_q, frame_done_d;
    logic                    xfer;
    logic [3:0]              nib [NUM_DIGITS];

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        xfer         = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                    xfer    = 1'b1;
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == BLANK_LAST) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHOW: begin
                if (!enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == SHOW_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d        = '0;
                        frame_done_d = 1'b1;
                        xfer         = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // A load coinciding with a transfer bypasses the shadow so the new frame uses it.
    always_comb begin
        shadow_d    = load ? load_data : shadow_q;
        shadow_dp_d = load ? load_dp : shadow_dp_q;
        pending_d   = load | pending_q;
        active_d    = active_q;
        active_dp_d = active_dp_q;
        if (xfer) begin
            if (load) begin
                active_d    = load_data;
                active_dp_d = load_dp;
                pending_d   = 1'b0;
            end else if (pending_q) begin
                active_d    = shadow_q;
                active_dp_d = shadow_dp_q;
                pending_d   = 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign nib[gi] = active_d[4*gi +: 4];
        end
    endgenerate

    // Outputs are computed from next-state values so the registers line up with the state.
    always_comb begin
        bcd_d      = 4'd0;
        dp_d       = 1'b0;
        digit_en_d = '0;
        if (state_d != IDLE) begin
            bcd_d = nib[idx_d];
            dp_d  = active_dp_d[idx_d];
        end
        if (state_d == SHOW) begin
            digit_en_d = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            active_q     <= '0;
            active_dp_q  <= '0;
            pending_q    <= 1'b0;
            bcd_q        <= 4'd0;
            dp_q         <= 1'b0;
            digit_en_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            active_q     <= active_d;
            active_dp_q  <= active_dp_d;
            pending_q    <= pending_d;
            bcd_q        <= bcd_d;
            dp_q         <= dp_d;
            digit_en_q   <= digit_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bcd_out    = bcd_q;
    assign dp_out     = dp_q;
    assign digit_en   = digit_en_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 4 digits, 8-cycle slots and 2 blank cycles.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] load_data;
    logic [3:0]  load_dp;
    logic [3:0]  bcd_out;
    logic        dp_out;
    logic [3:0]  digit_en;
    logic        frame_done;
    logic        pending;

    int tests_run    = 0;
    int tests_failed = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .load      (load),
        .load_data (load_data),
        .load_dp   (load_dp),
        .bcd_out   (bcd_out),
        .dp_out    (dp_out),
        .digit_en  (digit_en),
        .frame_done(frame_done),
        .pending   (pending)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs at cycle c of a 32-cycle frame (slot = c/8, first 2 cycles blank).
    function automatic logic [3:0] e_en(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ((c % 8) < 2) ? 4'b0000 : (one << (c / 8));
    endfunction

    function automatic logic [3:0] e_bcd(input logic [15:0] d, input int c);
        return d[(c / 8) * 4 +: 4];
    endfunction

    function automatic logic e_dp(input logic [3:0] p, input int c);
        return p[c / 8];
    endfunction

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; load = 1'b0; load_data = '0; load_dp = '0;
        tick();
        tick();
        rst = 1'b0;
        $display("[TB] reset released");
        for (int k = 0; k < 50; k++) begin
            tests_run++;
            if ({bcd_out, dp_out, digit_en, frame_done, pending} !== 11'd0) begin
                tests_failed++;
                $display("FAIL reset_idle k=%0d got bcd=%h dp=%b en=%b fd=%b pend=%b, want all 0",
                         k, bcd_out, dp_out, digit_en, frame_done, pending);
            end
            tick();
        end
    endtask

    task automatic test_basic_scan();
        logic [3:0] x_en, x_bcd;
        logic       x_dp, x_fd;
        load = 1'b1; load_data = 16'h4321; load_dp = 4'b0100;
        tick();
        load = 1'b0;
        $display("[TB] load 0x4321 dp=0100");
        tests_run++;
        if (pending !== 1'b1 || digit_en !== 4'b0000) begin
            tests_failed++;
            $display("FAIL load_pending got pend=%b en=%b, want pend=1 en=0000", pending, digit_en);
        end
        enable = 1'b1;
        tick();
        $display("[TB] enable=1");
        for (int c = 0; c < 64; c++) begin
            x_en = e_en(c % 32); x_bcd = e_bcd(16'h4321, c % 32);
            x_dp = e_dp(4'b0100, c % 32); x_fd = (c == 32);
            tests_run++;
            if ({digit_en, bcd_out, dp_out, frame_done, pending} !== {x_en, x_bcd, x_dp, x_fd, 1'b0}) begin
                tests_failed++;
                $display("FAIL basic_scan c=%0d got en=%b bcd=%h dp=%b fd=%b pend=%b, want en=%b bcd=%h dp=%b fd=%b pend=0",
                         c, digit_en, bcd_out, dp_out, frame_done, pending, x_en, x_bcd, x_dp, x_fd);
            end
            tick();
        end
    endtask

    task automatic test_frame_update();
        logic [15:0] d;
        logic [3:0]  p, x_en, x_bcd;
        logic        x_dp, x_fd, x_pend;
        for (int c = 0; c < 64; c++) begin
            d = (c < 32) ? 16'h4321 : 16'h8765;
            p = (c < 32) ? 4'b0100 : 4'b0000;
            x_en = e_en(c % 32); x_bcd = e_bcd(d, c % 32); x_dp = e_dp(p, c % 32);
            x_fd = ((c % 32) == 0); x_pend = (c >= 9 && c < 32);
            tests_run++;
            if ({digit_en, bcd_out, dp_out, frame_done, pending} !== {x_en, x_bcd, x_dp, x_fd, x_pend}) begin
                tests_failed++;
                $display("FAIL frame_update c=%0d got en=%b bcd=%h dp=%b fd=%b pend=%b, want en=%b bcd=%h dp=%b fd=%b pend=%b",
                         c, digit_en, bcd_out, dp_out, frame_done, pending, x_en, x_bcd, x_dp, x_fd, x_pend);
            end
            if (c == 8) begin
                load = 1'b1; load_data = 16'h8765; load_dp = 4'b0000;
                $display("[TB] load 0x8765 during digit 1");
            end
            tick();
            load = 1'b0;
        end
    endtask

    task automatic test_coincident_load();
        logic [15:0] d;
        logic [3:0]  x_en, x_bcd;
        logic        x_fd;
        for (int c = 0; c < 64; c++) begin
            d = (c < 32) ? 16'h8765 : 16'h9999;
            x_en = e_en(c % 32); x_bcd = e_bcd(d, c % 32); x_fd = ((c % 32) == 0);
            tests_run++;
            if ({digit_en, bcd_out, dp_out, frame_done, pending} !== {x_en, x_bcd, 1'b0, x_fd, 1'b0}) begin
                tests_failed++;
                $display("FAIL coincident c=%0d got en=%b bcd=%h dp=%b fd=%b pend=%b, want en=%b bcd=%h dp=0 fd=%b pend=0",
                         c, digit_en, bcd_out, dp_out, frame_done, pending, x_en, x_bcd, x_fd);
            end
            if (c == 31) begin
                load = 1'b1; load_data = 16'h9999; load_dp = 4'b0000;
                $display("[TB] load 0x9999 in transfer cycle");
            end
            tick();
            load = 1'b0;
        end
    endtask

    task automatic test_enable_drop();
        logic [3:0] x_en, x_bcd;
        logic       x_fd;
        for (int c = 0; c <= 20; c++) begin
            x_en = e_en(c); x_bcd = e_bcd(16'h9999, c); x_fd = (c == 0);
            tests_run++;
            if ({digit_en, bcd_out, frame_done} !== {x_en, x_bcd, x_fd}) begin
                tests_failed++;
                $display("FAIL pre_drop c=%0d got en=%b bcd=%h fd=%b, want en=%b bcd=%h fd=%b",
                         c, digit_en, bcd_out, frame_done, x_en, x_bcd, x_fd);
            end
            if (c < 20) tick();
        end
        enable = 1'b0;
        $display("[TB] enable=0 during digit 2 show");
        for (int k = 0; k < 10; k++) begin
            tick();
            tests_run++;
            if ({digit_en, frame_done, pending} !== 6'd0) begin
                tests_failed++;
                $display("FAIL enable_drop k=%0d got en=%b fd=%b pend=%b, want en=0000 fd=0 pend=0",
                         k, digit_en, frame_done, pending);
            end
        end
        enable = 1'b1;
        tick();
        $display("[TB] enable=1 again");
        for (int c = 0; c < 32; c++) begin
            x_en = e_en(c); x_bcd = e_bcd(16'h9999, c);
            tests_run++;
            if ({digit_en, bcd_out, dp_out, frame_done} !== {x_en, x_bcd, 1'b0, 1'b0}) begin
                tests_failed++;
                $display("FAIL reenable c=%0d got en=%b bcd=%h dp=%b fd=%b, want en=%b bcd=%h dp=0 fd=0",
                         c, digit_en, bcd_out, dp_out, frame_done, x_en, x_bcd);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [3:0] x_en, x_bcd;
        logic       x_fd, x_pend;
        for (int c = 0; c <= 27; c++) begin
            x_en = e_en(c); x_bcd = e_bcd(16'h9999, c); x_fd = (c == 0); x_pend = (c >= 9);
            tests_run++;
            if ({digit_en, bcd_out, frame_done, pending} !== {x_en, x_bcd, x_fd, x_pend}) begin
                tests_failed++;
                $display("FAIL pre_reset c=%0d got en=%b bcd=%h fd=%b pend=%b, want en=%b bcd=%h fd=%b pend=%b",
                         c, digit_en, bcd_out, frame_done, pending, x_en, x_bcd, x_fd, x_pend);
            end
            if (c == 8) begin
                load = 1'b1; load_data = 16'h5555; load_dp = 4'b1111;
                $display("[TB] load 0x5555 dp=1111");
            end
            if (c < 27) begin
                tick();
                load = 1'b0;
            end
        end
        rst = 1'b1;
        $display("[TB] rst=1 during digit 3 show");
        tick();
        tests_run++;
        if ({bcd_out, dp_out, digit_en, frame_done, pending} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_mid got bcd=%h dp=%b en=%b fd=%b pend=%b, want all 0",
                     bcd_out, dp_out, digit_en, frame_done, pending);
        end
        rst = 1'b0;
        tick();
        $display("[TB] rst released with enable=1");
        for (int c = 0; c < 32; c++) begin
            x_en = e_en(c);
            tests_run++;
            if ({digit_en, bcd_out, dp_out, frame_done, pending} !== {x_en, 4'h0, 1'b0, 1'b0, 1'b0}) begin
                tests_failed++;
                $display("FAIL post_reset c=%0d got en=%b bcd=%h dp=%b fd=%b pend=%b, want en=%b bcd=0 dp=0 fd=0 pend=0",
                         c, digit_en, bcd_out, dp_out, frame_done, pending, x_en);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_frame_update();
        test_coincident_load();
        test_enable_drop();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode/cathode multi-digit seven-segment display. It drives the shared `decoder` segment datapath with one BCD nibble at a time and asserts the matching digit enable. It double-buffers display data so that updates take effect only on frame boundaries, which prevents tearing. It inserts blanking gaps between digits to suppress ghosting. It sits between the register/control logic that produces display values and the `decoder` + pad drivers.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_DIV, 1000, clock cycles per digit slot, blank plus show (> BLANK_CYCLES)
BLANK_CYCLES, 2, cycles per slot with all digits off before the enable asserts (>= 1)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
enable  in  1  scanning enabled; low forces display dark
load  in  1  single-cycle write strobe for the shadow buffer
load_data  in  4*NUM_DIGITS  BCD nibbles; digit i = bits [4i+3:4i]
load_dp  in  NUM_DIGITS  decimal point per digit
bcd_out  out  4  nibble to the decoder for the current digit
dp_out  out  1  decimal point for the current digit
digit_en  out  NUM_DIGITS  one-hot active-high digit enable; all-zero when dark
frame_done  out  1  one-cycle pulse when the last digit's slot ends
pending  out  1  shadow holds data not yet transferred to active

Behaviour:
- All outputs are registered. Reset (rst=1 at an edge) has the following effect:
  - state=IDLE, idx=0, slot counter=0.
  - shadow, active and pending are cleared.
  - bcd_out=0, dp_out=0, digit_en=0, frame_done=0.
  - Reset mid-scan aborts immediately; pending load data is lost.
- States:
  - IDLE: digit_en=0. If enable=1, go to BLANK with idx=0 and counter=0, and do a frame transfer.
  - BLANK: digit_en=0, bcd_out/dp_out=active[idx]. After BLANK_CYCLES cycles, go to SHOW.
  - SHOW: digit_en=1<<idx. After REFRESH_DIV-BLANK_CYCLES cycles, do end-of-slot:
    - idx=(idx+1) mod NUM_DIGITS, then go to BLANK.
    - If idx was NUM_DIGITS-1: pulse frame_done in the cycle after the last SHOW cycle, and do a frame transfer.
- Frame period is NUM_DIGITS*REFRESH_DIV cycles. Slot timing is exact; there are no idle cycles between slots.
- Load:
  - load=1 writes load_data/load_dp into shadow and sets pending=1 the next cycle.
  - Loads are accepted in any state, including IDLE and reset-release cycle+1.
  - Back-to-back loads: last write wins.
- Frame transfer: if pending=1, active<=shadow and pending<=0.
- Simultaneous load and frame transfer in the same cycle:
  - load_data is written to both shadow and active; pending ends 0.
  - The new value is visible starting with digit 0 of the frame that is starting.
- Active data never changes mid-frame. The bcd_out for a digit is stable for its whole slot, including blank.
- enable deasserted in BLANK/SHOW:
  - Next cycle goes to IDLE with digit_en=0; idx/counter reset to 0.
  - No frame_done pulse; shadow and pending are preserved.
- Re-enable always starts at digit 0 with a BLANK slot.
- Counter width is clog2(REFRESH_DIV). Idx wraps cleanly for non-power-of-two NUM_DIGITS.
- digit_en is never more than one-hot. It is never nonzero in the same cycle that bcd_out changes.

Test Plan:
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, clock period 20.
1. Reset/idle:
   - Stimulus: rst=1 for 2 cycles, enable=0, load=0.
   - Required: all outputs 0 and remain 0 for 50 cycles.
2. Basic scan:
   - Stimulus: load 0x4321 with dp=4'b0100, then enable=1.
   - Required per slot: digit_en 0,0 then 0001 ×6 with bcd_out=1; then 0,0,0010 ×6 with bcd_out=2; ...; digit 2 has dp_out=1.
   - Required: frame_done pulses every 32 cycles.
3. Frame-synchronous update:
   - Stimulus: while showing digit 1 of 0x4321, load 0x8765.
   - Required: pending=1 and digits 2,3 still show 3,4; the next frame shows 5,6,7,8; pending clears at the transfer.
4. Coincident load and transfer:
   - Stimulus: assert load=0x9999 in the exact transfer cycle.
   - Required: the next frame shows 9,9,9,9 and pending=0.
5. Enable drop:
   - Stimulus: drop enable during digit 2 SHOW.
   - Required: digit_en=0 next cycle and no frame_done.
   - Stimulus: re-enable.
   - Required: restarts at digit 0 with 2 blank cycles.
6. Reset mid-scan:
   - Stimulus: rst=1 during digit 3 SHOW with pending=1.
   - Required: next cycle all outputs 0 and pending=0; after release with enable=1, displays 0,0,0,0.
